mem_port_arbiter: RTL and testbench

// Controller for the single shared instruction/data memory port of the IF stage.

---
 rtl/mem_port_arbiter_if.sv | 27 ++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of request/grant signals between the IF/MEM stages and the shared
// memory-port arbiter; master = pipeline side, slave = arbiter side.
interface mem_port_arbiter_if #(
  parameter int CNT_W = 16
) ();
  logic             fetch_req;
  logic             dmem_rd;
  logic             dmem_wr;
  logic             wdata_src;
  logic             sel_addr;
  logic             sel_wdata;
  logic             mem_ctrl;
  logic             pc_write;
  logic             fetch_valid;
  logic             dmem_done;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output fetch_req, dmem_rd, dmem_wr, wdata_src,
    input  sel_addr, sel_wdata, mem_ctrl, pc_write, fetch_valid, dmem_done, stall_count
  );

  modport slave (
    input  fetch_req, dmem_rd, dmem_wr, wdata_src,
    output sel_addr, sel_wdata, mem_ctrl, pc_write, fetch_valid, dmem_done, stall_count
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single instruction/data memory port: data accesses win over
// fetch, each access occupies the port for MEM_LAT cycles, all outputs registered.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam int               CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0]    CNT_LOAD  = CW'(MEM_LAT - 1);
  localparam logic             LOAD_LAST = (MEM_LAT == 1) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          op_wr_r;
  logic          arb_s;
  logic          req_data_s;

  // Arbitration point: port idle, or the current access ends this cycle
  assign arb_s      = (state_r == IDLE) || (cnt_r == {CW{1'b0}});
  assign req_data_s = bus.dmem_rd | bus.dmem_wr;

  // Port FSM with all outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r          <= IDLE;
      cnt_r            <= {CW{1'b0}};
      op_wr_r          <= 1'b0;
      bus.sel_addr     <= 1'b0;
      bus.sel_wdata    <= 1'b0;
      bus.mem_ctrl     <= 1'b1;
      bus.pc_write     <= 1'b0;
      bus.fetch_valid  <= 1'b0;
      bus.dmem_done    <= 1'b0;
      bus.stall_count  <= {CNT_W{1'b0}};
    end else begin
      if (bus.fetch_req && !bus.fetch_valid && (bus.stall_count != STALL_MAX)) begin
        bus.stall_count <= bus.stall_count + CNT_W'(1);
      end

      if (arb_s) begin
        if (req_data_s) begin
          // A simultaneous read and write is served as a write
          state_r         <= DATA;
          cnt_r           <= CNT_LOAD;
          op_wr_r         <= bus.dmem_wr;
          bus.sel_wdata   <= bus.wdata_src;
          bus.sel_addr    <= 1'b1;
          bus.mem_ctrl    <= ~bus.dmem_wr;
          bus.dmem_done   <= LOAD_LAST;
          bus.fetch_valid <= 1'b0;
          bus.pc_write    <= 1'b0;
        end else if (bus.fetch_req) begin
          state_r         <= FETCH;
          cnt_r           <= CNT_LOAD;
          bus.sel_addr    <= 1'b0;
          bus.mem_ctrl    <= 1'b1;
          bus.dmem_done   <= 1'b0;
          bus.fetch_valid <= LOAD_LAST;
          bus.pc_write    <= LOAD_LAST;
        end else begin
          state_r         <= IDLE;
          cnt_r           <= {CW{1'b0}};
          bus.sel_addr    <= 1'b0;
          bus.mem_ctrl    <= 1'b1;
          bus.dmem_done   <= 1'b0;
          bus.fetch_valid <= 1'b0;
          bus.pc_write    <= 1'b0;
        end
      end else begin
        cnt_r <= cnt_r - CW'(1);
        case (state_r)
          FETCH: begin
            bus.sel_addr    <= 1'b0;
            bus.mem_ctrl    <= 1'b1;
            bus.dmem_done   <= 1'b0;
            bus.fetch_valid <= (cnt_r == CW'(1));
            bus.pc_write    <= (cnt_r == CW'(1));
          end
          DATA: begin
            bus.sel_addr    <= 1'b1;
            bus.mem_ctrl    <= ~op_wr_r;
            bus.dmem_done   <= (cnt_r == CW'(1));
            bus.fetch_valid <= 1'b0;
            bus.pc_write    <= 1'b0;
          end
          default: begin
            state_r         <= IDLE;
            cnt_r           <= {CW{1'b0}};
            bus.sel_addr    <= 1'b0;
            bus.mem_ctrl    <= 1'b1;
            bus.dmem_done   <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.pc_write    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Three arbiter instances (MEM_LAT/CNT_W = 1/16, 3/16, 1/4) share one stimulus
// stream; each is checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  mem_port_arbiter_if #(.CNT_W(16)) if0 ();
  mem_port_arbiter_if #(.CNT_W(16)) if1 ();
  mem_port_arbiter_if #(.CNT_W(4))  if2 ();

  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(16)) u0 (.clock(clock), .reset(reset), .bus(if0));
  mem_port_arbiter #(.MEM_LAT(3), .CNT_W(16)) u1 (.clock(clock), .reset(reset), .bus(if1));
  mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4))  u2 (.clock(clock), .reset(reset), .bus(if2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: current access described by its kind and the cycle it ends in
  int lat   [3];
  int smax  [3];
  bit act   [3];
  bit isd   [3];
  bit iwr   [3];
  bit wsel  [3];
  int aend  [3];
  int stall [3];
  int cyc;

  task automatic expect_outs(input int i, output logic sa, output logic sw, output logic mc,
                             output logic pw, output logic fv, output logic dd);
    logic last;
    last = act[i] && (cyc == aend[i]);
    sa   = act[i] && isd[i];
    sw   = wsel[i];
    mc   = !(act[i] && isd[i] && iwr[i]);
    fv   = act[i] && !isd[i] && last;
    pw   = fv;
    dd   = act[i] && isd[i] && last;
  endtask

  task automatic model_update(input logic f, input logic r, input logic w, input logic s,
                              input logic rs);
    logic sa, sw, mc, pw, fv, dd;
    for (int i = 0; i < 3; i++) begin
      expect_outs(i, sa, sw, mc, pw, fv, dd);
      if (rs) begin
        act[i]   = 1'b0;
        wsel[i]  = 1'b0;
        stall[i] = 0;
      end else begin
        if (f && !fv && stall[i] < smax[i]) stall[i] = stall[i] + 1;
        if (!act[i] || cyc == aend[i]) begin
          if (r || w) begin
            act[i] = 1'b1; isd[i] = 1'b1; iwr[i] = w; wsel[i] = s; aend[i] = cyc + lat[i];
          end else if (f) begin
            act[i] = 1'b1; isd[i] = 1'b0; aend[i] = cyc + lat[i];
          end else begin
            act[i] = 1'b0;
          end
        end
      end
    end
    cyc = cyc + 1;
  endtask

  task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s[u%0d] cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic sa, input logic sw, input logic mc,
                          input logic pw, input logic fv, input logic dd, input logic [15:0] sc);
    logic esa, esw, emc, epw, efv, edd;
    expect_outs(i, esa, esw, emc, epw, efv, edd);
    chk("sel_addr",    i, 16'(sa), 16'(esa));
    chk("sel_wdata",   i, 16'(sw), 16'(esw));
    chk("mem_ctrl",    i, 16'(mc), 16'(emc));
    chk("pc_write",    i, 16'(pw), 16'(epw));
    chk("fetch_valid", i, 16'(fv), 16'(efv));
    chk("dmem_done",   i, 16'(dd), 16'(edd));
    chk("stall_count", i, sc, 16'(stall[i]));
  endtask

  task automatic check_all();
    chk_inst(0, if0.sel_addr, if0.sel_wdata, if0.mem_ctrl, if0.pc_write, if0.fetch_valid,
             if0.dmem_done, 16'(if0.stall_count));
    chk_inst(1, if1.sel_addr, if1.sel_wdata, if1.mem_ctrl, if1.pc_write, if1.fetch_valid,
             if1.dmem_done, 16'(if1.stall_count));
    chk_inst(2, if2.sel_addr, if2.sel_wdata, if2.mem_ctrl, if2.pc_write, if2.fetch_valid,
             if2.dmem_done, 16'(if2.stall_count));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check mid-cycle
  task automatic step(input logic f, input logic r, input logic w, input logic s, input logic rs);
    if0.fetch_req = f; if0.dmem_rd = r; if0.dmem_wr = w; if0.wdata_src = s;
    if1.fetch_req = f; if1.dmem_rd = r; if1.dmem_wr = w; if1.wdata_src = s;
    if2.fetch_req = f; if2.dmem_rd = r; if2.dmem_wr = w; if2.wdata_src = s;
    reset = rs;
    @(posedge clock);
    model_update(f, r, w, s, rs);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    bit f, r, w, s, rs;
    tests = 0;
    fails = 0;
    cyc   = 0;
    lat   = '{1, 3, 1};
    smax  = '{65535, 65535, 15};
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; isd[i] = 1'b0; iwr[i] = 1'b0; wsel[i] = 1'b0; aend[i] = 0; stall[i] = 0;
    end

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Plain fetch stream on an idle port
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_fetch_valid", 0, 16'(if0.fetch_valid), 16'd1);
    chk("t1_stall",       0, 16'(if0.stall_count), 16'd1);

    // One-cycle load interrupting the fetch stream
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_done",     0, 16'(if0.dmem_done),   16'd1);
    chk("t2_sel_addr", 0, 16'(if0.sel_addr),    16'd1);
    chk("t2_fv",       0, 16'(if0.fetch_valid), 16'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_resume",   0, 16'(if0.fetch_valid), 16'd1);
    chk("t2_stall",    0, 16'(if0.stall_count), 16'd2);

    // Three-cycle store with forwarded data while fetch waits
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_done",  1, 16'(if1.dmem_done),   16'd1);
    chk("t3_wsel",  1, 16'(if1.sel_wdata),   16'd1);
    chk("t3_stall", 1, 16'(if1.stall_count), 16'd3);

    // Read and write together act as a write
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_mem_ctrl", 0, 16'(if0.mem_ctrl), 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the second cycle of a long write, then a normal fetch
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_done",  1, 16'(if1.dmem_done), 16'd0);
    chk("t5_ctrl",  1, 16'(if1.mem_ctrl),  16'd1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_fetch", 1, 16'(if1.fetch_valid), 16'd1);

    // Stall counter saturation on the narrow instance
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_sat", 2, 16'(if2.stall_count), 16'd15);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      f  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 99) < 15);
      w  = ($urandom_range(0, 99) < 15);
      s  = $urandom_range(0, 1) == 1;
      rs = ($urandom_range(0, 99) < 2);
      step(f, r, w, s, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
